// File: rtl/ring_counter.sv
// One-hot ring counter: a single '1' circulates through WIDTH flops, one position per clock.
// Optional build macro RING_COUNTER_SELFCORRECT_EN reloads 0001 from any non-one-hot state.
module ring_counter #(
    parameter int WIDTH      = 4,
    parameter int SHIFT_LEFT = 1
) (
    input  logic             Clock,
    input  logic             Reset,
    output logic [WIDTH-1:0] Count_out
);

    localparam logic [WIDTH-1:0] SEED = WIDTH'(1);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
            $error("ring_counter: WIDTH must be in 2..32");
        end
    endgenerate

    logic [WIDTH-1:0] next_state;

    function automatic logic [WIDTH-1:0] rotate(input logic [WIDTH-1:0] s);
        if (SHIFT_LEFT != 0)
            return {s[WIDTH-2:0], s[WIDTH-1]};
        else
            return {s[0], s[WIDTH-1:1]};
    endfunction

`ifdef RING_COUNTER_SELFCORRECT_EN
    function automatic logic is_one_hot(input logic [WIDTH-1:0] s);
        return ($countones(s) == 1);
    endfunction
`endif

    always_comb begin
        next_state = rotate(Count_out);
`ifdef RING_COUNTER_SELFCORRECT_EN
        // Zero-hot or multi-hot states are replaced by the seed in a single cycle.
        if (!is_one_hot(Count_out))
            next_state = SEED;
`endif
    end

    always_ff @(posedge Clock) begin
        if (Reset)
            Count_out <= SEED;
        else
            Count_out <= next_state;
    end

endmodule

// File: tb/tb_ring_counter.sv
// Self-checking bench for ring_counter: three instances (4-bit left, 4-bit right, 8-bit left)
// compared every cycle against a slot-index reference model.
module tb_ring_counter;

    logic       Clock;
    logic       Reset;
    logic [3:0] out4l;
    logic [3:0] out4r;
    logic [7:0] out8;

    int total = 0;
    int bad   = 0;

    // Reference model: index of the hot slot per instance.
    int pos4l = 0;
    int pos4r = 0;
    int pos8  = 0;

    ring_counter #(.WIDTH(4), .SHIFT_LEFT(1)) dut4l (.Clock(Clock), .Reset(Reset), .Count_out(out4l));
    ring_counter #(.WIDTH(4), .SHIFT_LEFT(0)) dut4r (.Clock(Clock), .Reset(Reset), .Count_out(out4r));
    ring_counter #(.WIDTH(8), .SHIFT_LEFT(1)) dut8  (.Clock(Clock), .Reset(Reset), .Count_out(out8));

    initial Clock = 1'b0;
    always #10 Clock = ~Clock;

    function automatic logic [3:0] exp4(input int p);
        return 4'(1 << p);
    endfunction

    function automatic logic [7:0] exp8(input int p);
        return 8'(1 << p);
    endfunction

    // Apply one clock edge with the given Reset level, advance the model, settle at negedge.
    task automatic step(input logic r);
        Reset = r;
        @(posedge Clock);
        if (r) begin
            pos4l = 0;
            pos4r = 0;
            pos8  = 0;
        end else begin
            pos4l = (pos4l + 1) % 4;
            pos4r = (pos4r + 3) % 4;
            pos8  = (pos8 + 1) % 8;
        end
        @(negedge Clock);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            total++;
            if (out4l !== 4'b0001) begin
                bad++;
                $display("FAIL reset_4l edge %0d: got %b want 0001", i, out4l);
            end
            total++;
            if (out4r !== 4'b0001) begin
                bad++;
                $display("FAIL reset_4r edge %0d: got %b want 0001", i, out4r);
            end
            total++;
            if (out8 !== 8'h01) begin
                bad++;
                $display("FAIL reset_8 edge %0d: got %b want 00000001", i, out8);
            end
        end
    endtask

    task automatic test_rotate();
        logic [3:0] want;
        for (int i = 0; i < 25; i++) begin
            step(1'b0);
            want = exp4(pos4l);
            total++;
            if (out4l !== want) begin
                bad++;
                $display("FAIL rotate_4l cycle %0d: got %b want %b", i, out4l, want);
            end
            total++;
            if ($countones(out4l) != 1) begin
                bad++;
                $display("FAIL onehot_4l cycle %0d: got %b want one bit set", i, out4l);
            end
        end
    endtask

    task automatic test_mid_reset();
        int guard = 0;
        while (out4l !== 4'b0100 && guard < 8) begin
            step(1'b0);
            guard++;
        end
        total++;
        if (out4l !== 4'b0100) begin
            bad++;
            $display("FAIL mid_reset_reach: got %b want 0100 within 8 cycles", out4l);
        end
        step(1'b1);
        total++;
        if (out4l !== 4'b0001) begin
            bad++;
            $display("FAIL mid_reset_load: got %b want 0001", out4l);
        end
        step(1'b0);
        total++;
        if (out4l !== 4'b0010) begin
            bad++;
            $display("FAIL mid_reset_resume: got %b want 0010", out4l);
        end
    endtask

    task automatic test_shift_right();
        logic [3:0] seq [5];
        seq[0] = 4'b0001; seq[1] = 4'b1000; seq[2] = 4'b0100; seq[3] = 4'b0010; seq[4] = 4'b0001;
        step(1'b1);
        total++;
        if (out4r !== seq[0]) begin
            bad++;
            $display("FAIL shift_right_seed: got %b want %b", out4r, seq[0]);
        end
        for (int i = 1; i < 5; i++) begin
            step(1'b0);
            total++;
            if (out4r !== seq[i]) begin
                bad++;
                $display("FAIL shift_right step %0d: got %b want %b", i, out4r, seq[i]);
            end
        end
    endtask

    task automatic test_width8();
        int last_hit = -1;
        step(1'b1);
        for (int i = 1; i <= 24; i++) begin
            step(1'b0);
            total++;
            if (out8 !== exp8(pos8)) begin
                bad++;
                $display("FAIL width8 cycle %0d: got %b want %b", i, out8, exp8(pos8));
            end
            if (out8 === 8'h01) begin
                if (last_hit >= 0) begin
                    total++;
                    if (i - last_hit != 8) begin
                        bad++;
                        $display("FAIL width8_period: got %0d want 8", i - last_hit);
                    end
                end
                last_hit = i;
            end
        end
        total++;
        if (last_hit != 24) begin
            bad++;
            $display("FAIL width8_last_wrap: got cycle %0d want 24", last_hit);
        end
    endtask

    task automatic test_random();
        logic r;
        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 9) == 0);
            step(r);
            total++;
            if (out4l !== exp4(pos4l)) begin
                bad++;
                $display("FAIL random_4l cycle %0d: got %b want %b", i, out4l, exp4(pos4l));
            end
            total++;
            if (out4r !== exp4(pos4r)) begin
                bad++;
                $display("FAIL random_4r cycle %0d: got %b want %b", i, out4r, exp4(pos4r));
            end
            total++;
            if (out8 !== exp8(pos8)) begin
                bad++;
                $display("FAIL random_8 cycle %0d: got %b want %b", i, out8, exp8(pos8));
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        test_reset();
        test_rotate();
        test_mid_reset();
        test_shift_right();
        test_width8();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
